secure_data_fifo: RTL and testbench
===================================

SECURE_DATA_FIFO -- requirements
Module: secure_data_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 128, payload width in bits (>=8).
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (>=2; need not be a power of two).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, producer offers in_data.
REQ-006 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, sensitive payload.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a stored entry.
REQ-009 SHALL have port out_ready, input, 1, consumer takes out_data.
REQ-010 SHALL have port out_data, output, DATA_W, head entry; all-zero whenever out_valid=0.
REQ-011 SHALL have port zeroize, input, 1, request to wipe all storage.
REQ-012 SHALL have port busy, output, 1, wipe or check in progress.
REQ-013 SHALL have port count, output, $clog2(DEPTH+1), occupied entries.
REQ-014 SHALL have port zero_err, output, 1, sticky check failure (present only with SDF_ZERO_CHECK_EN).

Function
REQ-015 SHALL implement FSM states IDLE, SWEEP, CHECK; push/pop only in IDLE.
REQ-016 SHALL drive in_ready = (state==IDLE) && !full && !zeroize; push = in_valid && in_ready.
REQ-017 SHALL drive out_valid = (state==IDLE) && !empty && !zeroize; pop = out_valid && out_ready.
REQ-018 SHALL make a pushed word visible on out_data no earlier than the next cycle (empty-to-valid latency 1).
REQ-019 SHALL write zero into the entry at rd_ptr on the same edge it is popped; no consumed data remains in storage.
REQ-020 SHALL wrap wr_ptr and rd_ptr from DEPTH-1 to 0.
REQ-021 SHALL on simultaneous push and pop keep count unchanged and advance both pointers.
REQ-022 SHALL, when zeroize=1 in IDLE, enter SWEEP next edge and clear wr_ptr, rd_ptr, count on that edge; any push/pop in that cycle is blocked.
REQ-023 SHALL in SWEEP clear entry idx (0..DEPTH-1), one per cycle, returning after DEPTH cycles to IDLE (or CHECK if enabled).
REQ-024 SHALL hold busy=1 in SWEEP and CHECK, 0 in IDLE.
REQ-025 SHALL ignore zeroize while busy=1.

Reset
REQ-026 SHALL on reset asynchronously zero every storage entry, pointers, count, sweep index, zero_err; state=IDLE.
REQ-027 SHALL after reset present in_ready=1, out_valid=0, out_data=0, busy=0, count=0.
REQ-028 SHALL on reset mid-SWEEP/CHECK abandon the operation; post-reset storage is all-zero.

Configuration
REQ-029 SHALL, with SDF_ZERO_CHECK_EN defined, follow SWEEP with CHECK: read entry idx 0..DEPTH-1, one per cycle, set zero_err if any bit nonzero, then IDLE (DEPTH extra busy cycles).
REQ-030 SHALL, without SDF_ZERO_CHECK_EN, omit the CHECK state and the zero_err port; SWEEP returns directly to IDLE.

Structure
REQ-031 SHALL place the state enum typedef (IDLE, SWEEP, CHECK) in shared package secure_buf_pkg.
REQ-032 SHALL implement storage as one sub-module secure_data_fifo_mem (DEPTH x DATA_W, one write port with clear, async read); the FSM and pointers stay in the top.

Verification (DATA_W=128, DEPTH=4)
REQ-033 SHALL push 0xA5..A5 and 0x3C..3C, pop both -> out_data in order, each mem entry reads 0 after its pop, out_data=0 after the last pop.
REQ-034 SHALL push 4 words -> in_ready=0, count=4; 5th in_valid ignored; then push+pop while partly full -> count unchanged.
REQ-035 SHALL push 6 and pop 6 interleaved -> pointers wrap, FIFO order preserved.
REQ-036 SHALL with 3 entries assert zeroize -> busy for 4 cycles (8 with SDF_ZERO_CHECK_EN), count=0, all entries 0, zero_err=0.
REQ-037 SHALL assert reset during SWEEP at idx=2 -> all outputs at reset values, storage all-zero, next push accepted.
REQ-038 SHALL with SDF_ZERO_CHECK_EN force a stuck bit in entry 1 during SWEEP -> zero_err=1 after CHECK, held until reset.

Source files
------------

// File: rtl/secure_buf_pkg.sv
// Shared types for the secure data FIFO: controller state encoding.
package secure_buf_pkg;

    localparam int unsigned SDF_STATE_W = 2;

    typedef enum logic [SDF_STATE_W-1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2
    } sdf_state_e;

endpackage

// File: rtl/secure_data_fifo_mem.sv
// Secure FIFO storage: DEPTH x DATA_W registers, one write port, one clear port,
// asynchronous read; every entry is wiped on reset.
module secure_data_fifo_mem #(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              clr,
    input  logic [AW-1:0]     clr_addr,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear and write never target the same entry; write is ordered last regardless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr) begin
                mem[clr_addr] <= '0;
            end
            if (we) begin
                mem[waddr] <= wdata;
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/secure_data_fifo.sv
// Secure data FIFO: zero-on-pop storage with a zeroize sweep of all entries.
// Optional read-back verification of the sweep is enabled by SDF_ZERO_CHECK_EN.
module secure_data_fifo
    import secure_buf_pkg::*;
#(
    parameter  int unsigned DATA_W = 128,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              zeroize,
    output logic              busy,
    output logic [CNT_W-1:0]  count
`ifdef SDF_ZERO_CHECK_EN
    ,
    output logic              zero_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);

    sdf_state_e        state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     idx;
    logic              full;
    logic              empty;
    logic              idle;
    logic              push;
    logic              pop;
    logic              clr;
    logic [AW-1:0]     clr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign idle      = (state == IDLE);
    assign busy      = !idle;
    assign in_ready  = idle && !full && !zeroize;
    assign out_valid = idle && !empty && !zeroize;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? rd_data : '0;

    // The clear port serves both the pop wipe and the sweep; reads follow the check index.
    assign clr      = pop || (state == SWEEP);
    assign clr_addr = (state == SWEEP) ? idx : rd_ptr;
    assign rd_addr  = (state == CHECK) ? idx : rd_ptr;

    secure_data_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .reset    (reset),
        .we       (push),
        .waddr    (wr_ptr),
        .wdata    (in_data),
        .clr      (clr),
        .clr_addr (clr_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Controller: FIFO bookkeeping in IDLE, indexed wipe in SWEEP, read-back in CHECK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            idx    <= '0;
`ifdef SDF_ZERO_CHECK_EN
            zero_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (zeroize) begin
                        state  <= SWEEP;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                        idx    <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= inc_ptr(wr_ptr);
                        end
                        if (pop) begin
                            rd_ptr <= inc_ptr(rd_ptr);
                        end
                        if (push && !pop) begin
                            count <= count + CNT_W'(1);
                        end else if (pop && !push) begin
                            count <= count - CNT_W'(1);
                        end
                    end
                end
                SWEEP: begin
                    if (idx == AW'(DEPTH - 1)) begin
                        idx <= '0;
`ifdef SDF_ZERO_CHECK_EN
                        state <= CHECK;
`else
                        state <= IDLE;
`endif
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
`ifdef SDF_ZERO_CHECK_EN
                CHECK: begin
                    if (rd_data != '0) begin
                        zero_err <= 1'b1;
                    end
                    if (idx == AW'(DEPTH - 1)) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secure_data_fifo.sv
// Directed self-checking bench for secure_data_fifo (DATA_W=128, DEPTH=4).
// Build with SDF_ZERO_CHECK_EN to also cover the post-sweep read-back check.
module tb_secure_data_fifo;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
`ifdef SDF_ZERO_CHECK_EN
    localparam int EXP_BUSY = 8;
`else
    localparam int EXP_BUSY = 4;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              zeroize;
    logic              busy;
    logic [CNT_W-1:0]  count;
`ifdef SDF_ZERO_CHECK_EN
    logic              zero_err;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    secure_data_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .zeroize   (zeroize),
        .busy      (busy),
        .count     (count)
`ifdef SDF_ZERO_CHECK_EN
        ,
        .zero_err  (zero_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] word(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        zeroize   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else pass_cnt++;
`ifdef SDF_ZERO_CHECK_EN
        total_cnt++; if (zero_err !== 1'b0) $display("FAIL reset_zero_err got %b want 0", zero_err); else pass_cnt++;
`endif
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] a5, c3;
        a5 = {16{8'hA5}};
        c3 = {16{8'h3C}};
        tick();
        push_word(a5);
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL basic_latency got %b want 1", out_valid); else pass_cnt++;
        push_word(c3);
        total_cnt++; if (count !== CNT_W'(2)) $display("FAIL basic_count got %0d want 2", count); else pass_cnt++;
        total_cnt++; if (out_data !== a5) $display("FAIL basic_head0 got %h want %h", out_data, a5); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (dut.u_mem.mem[0] !== '0) $display("FAIL basic_wipe0 got %h want 0", dut.u_mem.mem[0]); else pass_cnt++;
        total_cnt++; if (out_data !== c3) $display("FAIL basic_head1 got %h want %h", out_data, c3); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (dut.u_mem.mem[1] !== '0) $display("FAIL basic_wipe1 got %h want 0", dut.u_mem.mem[1]); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL basic_empty_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL basic_empty_data got %h want 0", out_data); else pass_cnt++;
    endtask

    task automatic test_full();
        logic [DATA_W-1:0] exp_order [3];
        for (int i = 1; i <= 4; i++) push_word(word(i));
        total_cnt++; if (count !== CNT_W'(4)) $display("FAIL full_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b want 0", in_ready); else pass_cnt++;
        push_word(word(5));
        total_cnt++; if (count !== CNT_W'(4)) $display("FAIL full_ignored_count got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (out_data !== word(1)) $display("FAIL full_head got %h want %h", out_data, word(1)); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (count !== CNT_W'(3)) $display("FAIL full_pop_count got %0d want 3", count); else pass_cnt++;
        in_valid = 1'b1;
        in_data  = word(6);
        #1;
        total_cnt++; if (out_data !== word(2)) $display("FAIL full_pp_head got %h want %h", out_data, word(2)); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++; if (count !== CNT_W'(3)) $display("FAIL full_pp_count got %0d want 3", count); else pass_cnt++;
        exp_order[0] = word(3);
        exp_order[1] = word(4);
        exp_order[2] = word(6);
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_data !== exp_order[i]) $display("FAIL full_drain%0d got %h want %h", i, out_data, exp_order[i]); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        total_cnt++; if (count !== '0) $display("FAIL full_drained_count got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        push_word(word(20));
        for (int i = 1; i < 6; i++) begin
            in_valid  = 1'b1;
            in_data   = word(20 + i);
            out_ready = 1'b1;
            #1;
            total_cnt++; if (out_data !== word(19 + i)) $display("FAIL wrap_order%0d got %h want %h", i, out_data, word(19 + i)); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        total_cnt++; if (out_data !== word(25)) $display("FAIL wrap_last got %h want %h", out_data, word(25)); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        total_cnt++; if (count !== '0) $display("FAIL wrap_count got %0d want 0", count); else pass_cnt++;
    endtask

    task automatic test_zeroize();
        int n;
        for (int i = 0; i < 3; i++) push_word(word(40 + i));
        zeroize   = 1'b1;
        in_valid  = 1'b1;
        in_data   = word(50);
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL zero_in_blocked got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL zero_out_blocked got %b want 0", out_valid); else pass_cnt++;
        tick();
        zeroize   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (n == 2) zeroize = 1'b1;
            if (n == 3) zeroize = 1'b0;
            tick();
        end
        total_cnt++; if (n !== EXP_BUSY) $display("FAIL zero_busy_cycles got %0d want %0d", n, EXP_BUSY); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL zero_count got %0d want 0", count); else pass_cnt++;
        for (int i = 0; i < int'(DEPTH); i++) begin
            total_cnt++; if (dut.u_mem.mem[i] !== '0) $display("FAIL zero_entry%0d got %h want 0", i, dut.u_mem.mem[i]); else pass_cnt++;
        end
`ifdef SDF_ZERO_CHECK_EN
        total_cnt++; if (zero_err !== 1'b0) $display("FAIL zero_err_clean got %b want 0", zero_err); else pass_cnt++;
`endif
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL zero_idle_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_reset_mid_sweep();
        for (int i = 0; i < 4; i++) push_word(word(60 + i));
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_sweep_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (count !== '0) $display("FAIL rst_sweep_count got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_sweep_out_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== '0) $display("FAIL rst_sweep_out_data got %h want 0", out_data); else pass_cnt++;
        for (int i = 0; i < int'(DEPTH); i++) begin
            total_cnt++; if (dut.u_mem.mem[i] !== '0) $display("FAIL rst_sweep_entry%0d got %h want 0", i, dut.u_mem.mem[i]); else pass_cnt++;
        end
        #1;
        reset = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_sweep_in_ready got %b want 1", in_ready); else pass_cnt++;
        tick();
        push_word(word(70));
        total_cnt++; if (count !== CNT_W'(1)) $display("FAIL rst_sweep_push_count got %0d want 1", count); else pass_cnt++;
        total_cnt++; if (out_data !== word(70)) $display("FAIL rst_sweep_push_data got %h want %h", out_data, word(70)); else pass_cnt++;
    endtask

`ifdef SDF_ZERO_CHECK_EN
    task automatic test_stuck_bit();
        int n;
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        tick();
        tick();
        dut.u_mem.mem[1] = {{(DATA_W-1){1'b0}}, 1'b1};
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        total_cnt++; if (zero_err !== 1'b1) $display("FAIL stuck_zero_err got %b want 1", zero_err); else pass_cnt++;
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        total_cnt++; if (zero_err !== 1'b1) $display("FAIL stuck_sticky got %b want 1", zero_err); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (zero_err !== 1'b0) $display("FAIL stuck_reset_clear got %b want 0", zero_err); else pass_cnt++;
        reset = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_zeroize();
        test_reset_mid_sweep();
`ifdef SDF_ZERO_CHECK_EN
        test_stuck_bit();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
